pll_lock_supervisor: RTL

- Controls the reset and lock handshake of the on-chip PLL.
- Drives the PLL's active-high pll_rst and watches its asynchronous pll_lock.
- Releases a synchronized system reset only after lock has been continuously stable; reasserts it on lock loss.
- Retries relock a bounded number of times before flagging failure. Clocked by the PLL's reference input clock, so it runs whether or not the PLL output is valid.

---
 rtl/pll_lock_supervisor_if.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL / system.
// The supervisor uses the master modport; the PLL/system side uses slave.
interface pll_lock_supervisor_if #(
  parameter int LOSS_W = 8
);
  // pll_rst/pll_lock form a level handshake: pll_rst high holds the PLL in reset,
  // and pll_lock is only trusted after two clk_in flops, never sampled raw.
  logic              pll_lock;
  logic              retry_req;
  logic              pll_rst;
  logic              sys_rst_n;
  logic              pll_ok;
  logic              pll_fail;
  logic [LOSS_W-1:0] loss_cnt;
  logic [2:0]        state_o;

  modport master (
    input  pll_lock, retry_req,
    output pll_rst, sys_rst_n, pll_ok, pll_fail, loss_cnt, state_o
  );

  modport slave (
    output pll_lock, retry_req,
    input  pll_rst, sys_rst_n, pll_ok, pll_fail, loss_cnt, state_o
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset and lock, releasing the system reset only after lock has
// been stable; retries relock a bounded number of times before flagging failure.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int LOSS_W        = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  pll_lock_supervisor_if.master  bus
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                sync1_q, lock_s_q;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                pll_ok_q, pll_ok_d;
  logic                pll_fail_q, pll_fail_d;

  // Two-flop synchronizer; everything downstream decides on lock_s_q only.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_cnt_q  <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      pll_ok_q    <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_cnt_q  <= loss_cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      pll_ok_q    <= pll_ok_d;
      pll_fail_q  <= pll_fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    loss_cnt_d = loss_cnt_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the timeout edge wins over the timeout.
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_RESET_PLL;
          if (loss_cnt_q != {LOSS_W{1'b1}}) loss_cnt_d = loss_cnt_q + 1'b1;
        end
      end
      S_FAIL: begin
        if (bus.retry_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    // Outputs are registered from the next state so they line up with state_o.
    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    pll_ok_d    = (state_d == S_RUN);
    pll_fail_d  = (state_d == S_FAIL);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.pll_ok    = pll_ok_q;
  assign bus.pll_fail  = pll_fail_q;
  assign bus.loss_cnt  = loss_cnt_q;
  assign bus.state_o   = state_q;

endmodule
